// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the iterative mult/div units: latches operands, pulses start, stalls, writes back.
// Optional watchdog on the BUSY wait is enabled by defining MULTDIV_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for issue_valid; stall follows issue_valid
// START  | operands latched, one-cycle ctrl_MULT/ctrl_DIV pulse
// BUSY   | waiting for data_resultRDY (or the watchdog)
// DONE   | stall released, writeback beat presented
module multdiv_issue_ctrl #(
  parameter int RSTATUS_REG    = 30,
  parameter int MUL_EXC_CODE   = 4,
  parameter int DIV_EXC_CODE   = 5,
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic [4:0]  issue_rd,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // The watchdog count must fit the 6-bit counter.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 64) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range for the 6-bit watchdog");
  end

  logic [1:0]  state_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        is_div_q;
  logic [4:0]  rd_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        wb_exc_q;
  logic        timeout_hit;
  logic [31:0] exc_code;

  assign exc_code = is_div_q ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);

`ifdef MULTDIV_TIMEOUT_EN
  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT_CYCLES - 1);
  logic [5:0] tmo_cnt_q;

  // Fires on the BUSY edge that would bring the count to TIMEOUT_CYCLES.
  assign timeout_hit = (state_q == S_BUSY) && !data_resultRDY && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_q <= 6'd0;
    end else if (state_q == S_START) begin
      tmo_cnt_q <= 6'd0;
    end else if (state_q == S_BUSY && !data_resultRDY) begin
      tmo_cnt_q <= tmo_cnt_q + 6'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_a_q    <= 32'd0;
      op_b_q    <= 32'd0;
      is_div_q  <= 1'b0;
      rd_q      <= 5'd0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= 32'd0;
      wb_exc_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue_valid) begin
            op_a_q   <= issue_opA;
            op_b_q   <= issue_opB;
            is_div_q <= issue_is_div;
            rd_q     <= issue_rd;
            state_q  <= S_START;
          end
        end
        S_START: state_q <= S_BUSY;
        S_BUSY: begin
          if (data_resultRDY && !data_exception) begin
            wb_rd_q   <= rd_q;
            wb_data_q <= data_result;
            wb_exc_q  <= 1'b0;
            state_q   <= S_DONE;
          end else if (data_resultRDY || timeout_hit) begin
            wb_rd_q   <= 5'(RSTATUS_REG);
            wb_data_q <= exc_code;
            wb_exc_q  <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_operandA = op_a_q;
  assign data_operandB = op_b_q;
  assign ctrl_MULT     = (state_q == S_START) && !is_div_q;
  assign ctrl_DIV      = (state_q == S_START) && is_div_q;
  assign stall         = ((state_q == S_IDLE) && issue_valid) ||
                         (state_q == S_START) || (state_q == S_BUSY);
  // Normal writes to r0 are dropped; exception writes always go out.
  assign wb_valid      = (state_q == S_DONE) && (wb_exc_q || (wb_rd_q != 5'd0));
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Self-checking bench for multdiv_issue_ctrl: timeline model compared every cycle plus literal pins.
module tb_multdiv_issue_ctrl;
  localparam int BIG = 100000000;
  localparam int T   = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_is_div = 1'b0;
  logic [31:0] issue_opA = '0;
  logic [31:0] issue_opB = '0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] data_result = '0;
  logic        data_exception = 1'b0;
  logic        data_resultRDY = 1'b0;
  logic [31:0] data_operandA, data_operandB, wb_data;
  logic        ctrl_MULT, ctrl_DIV, stall, wb_valid;
  logic [4:0]  wb_rd;

  multdiv_issue_ctrl dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_is_div(issue_is_div),
    .issue_opA(issue_opA), .issue_opB(issue_opB), .issue_rd(issue_rd),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .data_result(data_result),
    .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_err = 0;
  int n_checks = 0;

  // Timeline of the current operation: acceptance edge, last BUSY cycle, reset abort.
  int acc_c = BIG, rdy_c = BIG, abort_c = 0;
  logic        m_div = 1'b0, m_exc = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_res = '0, exp_opa = '0, exp_opb = '0;
  bit          m_wb_zero = 1'b1;

  int cap_wb_n = 0, cap_wb_cyc = 0, cap_mult_n = 0, cap_div_n = 0, cap_ctrl_cyc = 0;
  logic [4:0]  cap_rd = '0;
  logic [31:0] cap_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  bit c_run, c_start, c_done;
  always @(negedge clock) begin
    if (cyc >= 1) begin
      c_run   = (cyc >= acc_c) && (cyc <= rdy_c) && (cyc < abort_c);
      c_start = (cyc == acc_c) && (cyc < abort_c);
      c_done  = (cyc == rdy_c + 1) && (cyc < abort_c);
      chk("ctrl_MULT", ctrl_MULT, c_start && !m_div);
      chk("ctrl_DIV", ctrl_DIV, c_start && m_div);
      chk("stall", stall, c_run || (issue_valid && !c_done));
      chk("wb_valid", wb_valid, c_done && (m_exc || m_rd != 5'd0));
      chk("operandA", data_operandA, exp_opa);
      chk("operandB", data_operandB, exp_opb);
      if (c_done) begin
        chk("wb_rd", wb_rd, m_exc ? 5'd30 : m_rd);
        chk("wb_data", wb_data, m_exc ? (m_div ? 32'd5 : 32'd4) : m_res);
      end
      if (m_wb_zero) begin
        chk("wb_rd_zero", wb_rd, 5'd0);
        chk("wb_data_zero", wb_data, 32'd0);
      end
      if (wb_valid) begin
        cap_wb_n++; cap_wb_cyc = cyc; cap_rd = wb_rd; cap_data = wb_data;
      end
      if (ctrl_MULT) cap_mult_n++;
      if (ctrl_DIV) cap_div_n++;
      if (ctrl_MULT || ctrl_DIV) cap_ctrl_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic clr_caps();
    cap_wb_n = 0; cap_mult_n = 0; cap_div_n = 0; cap_wb_cyc = 0; cap_ctrl_cyc = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    issue_valid = 1'b0;
    step();
    reset = 1'b0;
    abort_c = cyc;
    exp_opa = '0; exp_opb = '0; m_wb_zero = 1'b1;
  endtask

  // Raises the issue and returns in the START cycle; RDY is expected in cycle acc+lat.
  task automatic issue_only(input logic div, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input int lat, input logic exc,
                            input logic [31:0] res, input bit early);
    issue_valid = 1'b1; issue_is_div = div; issue_opA = a; issue_opB = b; issue_rd = rd;
    if (early) step();
    acc_c = cyc + 1; rdy_c = (lat >= BIG) ? BIG : acc_c + lat; abort_c = BIG;
    m_div = div; m_rd = rd; m_exc = exc; m_res = res; m_wb_zero = 1'b0;
    step();
    exp_opa = a; exp_opb = b;
    issue_valid = 1'b0; issue_is_div = ~div; issue_opA = ~a; issue_opB = ~b; issue_rd = ~rd;
  endtask

  // Full operation; returns in the DONE cycle.
  task automatic do_op(input logic div, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int lat, input logic exc,
                       input logic [31:0] res, input bit early, input bit rdy_in_done);
    issue_only(div, a, b, rd, lat, exc, res, early);
    repeat (lat) step();
    data_resultRDY = 1'b1; data_result = res; data_exception = exc;
    step();
    if (rdy_in_done) begin
      data_result = 32'hDEAD_BEEF; data_exception = ~exc;
    end else begin
      data_resultRDY = 1'b0; data_exception = 1'b0;
    end
  endtask

  task automatic finish_op();
    step();
    data_resultRDY = 1'b0; data_exception = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "bench timeout");
  end

  int d1;
  int scnt;
  logic [31:0] a_v, b_v;

  initial begin
    repeat (3) step();
    reset = 1'b0;
    chk("reset_stall", stall, 1'b0);
    chk("reset_opA", data_operandA, 32'd0);

    // Stale RDY while idle must be ignored.
    data_resultRDY = 1'b1; data_result = 32'd123;
    step();
    data_resultRDY = 1'b0;
    step();

    // MUL 7 * -3, rd=5
    clr_caps();
    a_v = 32'd7; b_v = 32'hFFFF_FFFD;
    do_op(1'b0, a_v, b_v, 5'd5, 4, 1'b0, a_v * b_v, 1'b0, 1'b0);
    finish_op();
    chk("mul_wb_n", cap_wb_n, 1);
    chk("mul_wb_rd", cap_rd, 5'd5);
    chk("mul_wb_data", cap_data, 32'hFFFF_FFEB);
    chk("mul_pulses", cap_mult_n, 1);
    chk("mul_no_div", cap_div_n, 0);
    chk("mul_latency", cap_wb_cyc - acc_c, 5);

    // MUL overflow with exception; RDY stays up into DONE with junk.
    clr_caps();
    do_op(1'b0, 32'h4000_0000, 32'd4, 5'd7, 3, 1'b1, 32'd0, 1'b0, 1'b1);
    finish_op();
    chk("mulx_wb_n", cap_wb_n, 1);
    chk("mulx_wb_rd", cap_rd, 5'd30);
    chk("mulx_wb_data", cap_data, 32'h0000_0004);

    // DIV with exception after 10 cycles.
    clr_caps();
    do_op(1'b1, 32'd100, 32'd0, 5'd9, 10, 1'b1, 32'd0, 1'b0, 1'b0);
    finish_op();
    chk("divx_pulses", cap_div_n, 1);
    chk("divx_no_mul", cap_mult_n, 0);
    chk("divx_wb_rd", cap_rd, 5'd30);
    chk("divx_wb_data", cap_data, 32'h0000_0005);

    // Plain DIV 100 / 7.
    clr_caps();
    do_op(1'b1, 32'd100, 32'd7, 5'd12, 6, 1'b0, 32'd14, 1'b0, 1'b0);
    finish_op();
    chk("div_wb_rd", cap_rd, 5'd12);
    chk("div_wb_data", cap_data, 32'd14);

    // MUL to r0 then MUL 5*5 held from the DONE cycle.
    clr_caps();
    do_op(1'b0, 32'd2, 32'd3, 5'd0, 2, 1'b0, 32'd6, 1'b0, 1'b0);
    d1 = cyc;
    do_op(1'b0, 32'd5, 32'd5, 5'd3, 3, 1'b0, 32'd25, 1'b1, 1'b0);
    finish_op();
    chk("b2b_wb_n", cap_wb_n, 1);
    chk("b2b_accept", cap_ctrl_cyc, d1 + 2);
    chk("b2b_wb_rd", cap_rd, 5'd3);
    chk("b2b_wb_data", cap_data, 32'd25);

    // Reset on the 5th BUSY cycle, late RDY afterwards.
    clr_caps();
    issue_only(1'b0, 32'd9, 32'd9, 5'd4, BIG, 1'b0, 32'd81, 1'b0);
    repeat (5) step();
    do_reset();
    step();
    data_resultRDY = 1'b1; data_result = 32'd81;
    step();
    data_resultRDY = 1'b0;
    repeat (3) step();
    chk("rst_wb_n", cap_wb_n, 0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_opA", data_operandA, 32'd0);

`ifdef MULTDIV_TIMEOUT_EN
    clr_caps();
    issue_only(1'b0, 32'd3, 32'd3, 5'd6, T, 1'b1, 32'd0, 1'b0);
    repeat (T + 1) step();
    step();
    chk("tmo_wb_n", cap_wb_n, 1);
    chk("tmo_latency", cap_wb_cyc - acc_c, T + 1);
    chk("tmo_wb_rd", cap_rd, 5'd30);
    chk("tmo_wb_data", cap_data, 32'h0000_0004);
`else
    clr_caps();
    issue_only(1'b1, 32'd3, 32'd3, 5'd6, BIG, 1'b0, 32'd0, 1'b0);
    scnt = 0;
    repeat (200) begin
      step();
      if (stall) scnt++;
    end
    chk("hang_stall_cycles", scnt, 200);
    chk("hang_wb_n", cap_wb_n, 0);
    do_reset();
    step();
    chk("hang_reset_stall", stall, 1'b0);
`endif

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/multdiv_issue_ctrl.md
Name: multdiv_issue_ctrl

Overview:
Processor-side initiator for the iterative mult/div units. Captures an issued MUL/DIV from the execute stage and holds operands stable for the whole operation. Pulses ctrl_MULT or ctrl_DIV for exactly one cycle, stalls the pipeline until data_resultRDY, then presents one writeback beat. Multiplier overflow or divide exception is turned into an rstatus write.

Parameters:
RSTATUS_REG, 30, destination register for exception writeback
MUL_EXC_CODE, 4, value written to RSTATUS_REG on multiply exception
DIV_EXC_CODE, 5, value written to RSTATUS_REG on divide exception
TIMEOUT_CYCLES, 40, watchdog limit in BUSY cycles (used only with MULTDIV_TIMEOUT_EN)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
issue_valid  in  1  execute stage holds a MUL/DIV instruction
issue_is_div  in  1  1=DIV, 0=MUL
issue_opA  in  32  operand A
issue_opB  in  32  operand B
issue_rd  in  5  destination register
data_operandA  out  32  latched operand A to the mult/div units
data_operandB  out  32  latched operand B to the mult/div units
ctrl_MULT  out  1  one-cycle multiply start
ctrl_DIV  out  1  one-cycle divide start
data_result  in  32  unit result
data_exception  in  1  unit exception, qualified by data_resultRDY
data_resultRDY  in  1  unit result valid
stall  out  1  freeze PC/F/D/X latches
wb_valid  out  1  one-cycle writeback strobe
wb_rd  out  5  writeback register
wb_data  out  32  writeback value

Behaviour:
- States: IDLE, START, BUSY, DONE. Encoding is free.
- Reset (synchronous, wins over all else, including mid-operation): state=IDLE. All registered outputs return 0: operands, op type, rd, wb_rd, wb_data, timeout counter. No ctrl pulse and no wb_valid in the cycle after reset.
- IDLE: issue_valid=1 latches opA, opB, is_div and rd; next state is START. issue_valid is sampled only in IDLE.
- START: ctrl_DIV=is_div and ctrl_MULT=~is_div, for this cycle only. Next state is BUSY.
- BUSY: wait for data_resultRDY=1. On that edge:
  - No exception: latch wb_data=data_result and wb_rd=rd.
  - data_exception=1: wb_rd=RSTATUS_REG, and wb_data=DIV_EXC_CODE or MUL_EXC_CODE zero-extended to 32 bits.
  - Next state is DONE.
- data_resultRDY in IDLE, START or DONE is ignored, including stale RDY from a previous op.
- DONE: stall=0. wb_valid=1 unless (no exception and rd==0); an exception always writes. Next state is IDLE. issue_valid still high here belongs to the completing instruction and is not re-accepted.
- stall is combinational: 1 when (IDLE and issue_valid), START, or BUSY; 0 otherwise.
- data_operandA/B come from registers and do not change from START until the next acceptance.
- ctrl_MULT and ctrl_DIV are never high simultaneously and never high outside START.
- Latency: acceptance at edge N, ctrl pulse in cycle N+1, wb_valid in the cycle after the RDY edge. Total = unit latency + 3 cycles.
- Back-to-back: a new issue is accepted no earlier than the IDLE cycle following DONE.

Optional Feature:
MULTDIV_TIMEOUT_EN
- Defined: a 6-bit counter clears in START and increments each BUSY cycle without RDY. When the count reaches TIMEOUT_CYCLES, the controller goes to DONE with the exception path forced (wb_rd=RSTATUS_REG, wb_data = the code for the op type).
- Not defined: the counter logic is absent and BUSY waits indefinitely.

Test Plan:
- MUL 7 * -3, rd=5 -> ctrl_MULT high exactly 1 cycle, ctrl_DIV never high, operands stable until RDY, wb_valid 1 cycle with wb_rd=5 and wb_data=0xFFFFFFEB; stall drops in the wb cycle.
- MUL 0x40000000 * 4, rd=7, unit exception -> wb_rd=30, wb_data=0x00000004.
- DIV model with RDY after 10 cycles and exception set, rd=9 -> ctrl_DIV single pulse, wb_rd=30, wb_data=0x00000005.
- MUL 2 * 3 with rd=0 -> full stall sequence, wb_valid never asserted. Then MUL 5 * 5, rd=3, held in the DONE cycle -> second op accepted only in the following IDLE, wb_data=25.
- Reset asserted on the 5th BUSY cycle, RDY pulsed 2 cycles later -> state IDLE, stall=0, no wb_valid, operands=0.
- With MULTDIV_TIMEOUT_EN, unit never asserts RDY -> wb_valid exactly TIMEOUT_CYCLES+1 cycles after START with wb_rd=30 and the op's code. Without the macro, stall stays 1 for 200 cycles.
